// File: rtl/clock_gate_pkg.sv
// Shared types and default sizing for the clock-gate sequencer.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    SETTLE
  } state_t;

  typedef enum logic {
    GATE,
    UNGATE
  } dir_t;

  localparam int DEF_NUM_CLK    = 4;
  localparam int DEF_IDLE_CYC   = 8;
  localparam int DEF_SETTLE_CYC = 4;

endpackage

// File: rtl/cg_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module cg_rr_arbiter #(
  parameter int NUM_CLK = 4,
  parameter int IDX_W   = $clog2(NUM_CLK)
) (
  input  logic [NUM_CLK-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_CLK-1:0] grant,
  output logic               valid
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_CLK; k++) begin
      idx = IDX_W'((int'(ptr) + int'(k)) % NUM_CLK);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_gate_sequencer.sv
// Owns per-domain clock-gate enables: idle hysteresis before gating, wake has
// priority, one transition at a time with a checker skip window around each edge.
module clock_gate_sequencer
  import clock_gate_pkg::*;
#(
  parameter int NUM_CLK    = DEF_NUM_CLK,
  parameter int IDLE_CYC   = DEF_IDLE_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int IDX_W      = $clog2(NUM_CLK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CLK-1:0] gate_req,
  input  logic               force_on,
  output logic [NUM_CLK-1:0] gate_en,
  output logic [NUM_CLK-1:0] chk_skip,
  output logic               busy,
  output logic               trans_done,
  output logic [IDX_W-1:0]   trans_idx
);

  localparam int CNT_W = $clog2(IDLE_CYC + 1);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  logic [NUM_CLK-1:0] req;
  logic [NUM_CLK-1:0] ungate_cand, gate_cand;
  logic [NUM_CLK-1:0] ungate_gnt, gate_gnt, pick_gnt;
  logic               ungate_vld, gate_vld, pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [CNT_W-1:0]   idle_cnt [NUM_CLK];

  state_t             state;
  dir_t               dir;
  logic [IDX_W-1:0]   sel, rr_ptr;
  logic [SET_W-1:0]   settle_cnt;
  logic               abort;
  logic [NUM_CLK-1:0] toggle_vec;

  always_comb begin
    req         = gate_req & {NUM_CLK{~force_on}};
    ungate_cand = gate_en & ~req;
    gate_cand   = '0;
    for (int unsigned i = 0; i < NUM_CLK; i++) begin
      if (!gate_en[i] && idle_cnt[i] == CNT_W'(IDLE_CYC)) gate_cand[i] = 1'b1;
    end
  end

  cg_rr_arbiter #(.NUM_CLK(NUM_CLK), .IDX_W(IDX_W)) u_arb_ungate (
    .req   (ungate_cand),
    .ptr   (rr_ptr),
    .grant (ungate_gnt),
    .valid (ungate_vld)
  );

  cg_rr_arbiter #(.NUM_CLK(NUM_CLK), .IDX_W(IDX_W)) u_arb_gate (
    .req   (gate_cand),
    .ptr   (rr_ptr),
    .grant (gate_gnt),
    .valid (gate_vld)
  );

  // Wake requests completely shadow gate requests in the same cycle.
  always_comb begin
    pick_gnt = ungate_vld ? ungate_gnt : gate_gnt;
    pick_vld = ungate_vld | gate_vld;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_CLK; i++) begin
      if (pick_gnt[i]) pick_idx = IDX_W'(i);
    end
  end

  always_comb begin
    abort      = (state == PREP) && (dir == GATE) && !req[sel];
    toggle_vec = '0;
    if (state == PREP && !abort) toggle_vec[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CLK; i++) idle_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CLK; i++) begin
        if (!req[i] || toggle_vec[i])
          idle_cnt[i] <= '0;
        else if (!gate_en[i] && idle_cnt[i] != CNT_W'(IDLE_CYC))
          idle_cnt[i] <= idle_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= GATE;
      sel        <= '0;
      rr_ptr     <= '0;
      settle_cnt <= '0;
      gate_en    <= '0;
      chk_skip   <= '0;
      busy       <= 1'b0;
      trans_done <= 1'b0;
      trans_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          trans_done <= 1'b0;
          if (pick_vld) begin
            sel       <= pick_idx;
            trans_idx <= pick_idx;
            dir       <= ungate_vld ? UNGATE : GATE;
            chk_skip  <= pick_gnt;
            busy      <= 1'b1;
            state     <= PREP;
          end
        end
        PREP: begin
          if (abort) begin
            chk_skip <= '0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            gate_en    <= gate_en ^ toggle_vec;
            settle_cnt <= '0;
            trans_done <= (SETTLE_CYC == 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          // trans_done is raised one edge early so it lands in the last SETTLE cycle.
          if (int'(settle_cnt) + 1 == SETTLE_CYC) begin
            chk_skip   <= '0;
            busy       <= 1'b0;
            trans_done <= 1'b0;
            rr_ptr     <= (sel == IDX_W'(NUM_CLK - 1)) ? '0 : sel + 1'b1;
            state      <= IDLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
            trans_done <= (int'(settle_cnt) + 2 == SETTLE_CYC);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
